// File: rtl/clk_divider_prog.sv
// Programmable integer clock divider (clk_in / N) with glitch-free ratio update at a period boundary.
// Define ODD_DUTY50_EN to add a falling-edge flop that gives exact 50% duty on odd ratios.
module clk_divider_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_N = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_n;
  logic [CNT_W-1:0] pend_n;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half_n;
  logic [CNT_W-1:0] load_n;
  logic             busy;
  logic             pos_q;
  logic             tick_q;
  logic             wrap;

  always_comb begin
    half_n  = act_n >> 1;
    wrap    = (cnt == (act_n - ONE));
    cnt_nxt = wrap ? '0 : (cnt + ONE);
    load_n  = (div_val < MIN_N) ? MIN_N : div_val;
  end

  // The ratio only switches on a wrap, when cnt returns to 0, so the counter never
  // sees an out-of-range value and the output never produces a runt pulse.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      act_n  <= DEF_N;
      pend_n <= DEF_N;
      busy   <= 1'b0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      if (en) begin
        cnt   <= cnt_nxt;
        pos_q <= (cnt_nxt < half_n);
        if (wrap && busy) begin
          act_n <= pend_n;
        end
      end
      tick_q <= en && wrap;
      // A load on the applying edge keeps busy set for the newly captured value.
      if (div_load) begin
        pend_n <= load_n;
        busy   <= 1'b1;
      end else if (en && wrap) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef ODD_DUTY50_EN
  logic neg_q;

  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  // Stretch the high phase by half a source cycle on odd ratios.
  assign clk_out = act_n[0] ? (pos_q | neg_q) : pos_q;
`else
  assign clk_out = pos_q;
`endif

  assign div_busy = busy;
  assign tick     = tick_q;

endmodule
